booth_seq_mult: RTL and testbench

Parametrised, multi-cycle radix-2 Booth multiplier that replaces the fixed 4-bit combinational Booth unit.
- Operand width is configurable; signed or unsigned mode is selected per operation.
- Uses one add/subtract-and-shift step per cycle, with a start/busy/done handshake.
- Serves as the shared multiply resource for datapaths that can tolerate WIDTH+1 cycles of latency in exchange for a small adder footprint.

---
 rtl/booth_seq_mult.sv | 129 ++++++++++++
 tb/tb_booth_seq_mult.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per cycle, start/busy/done handshake.
// Optional macro BOOTH_SEQ_MULT_ABORT_EN adds an abort input that cancels a running operation.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_SEQ_MULT_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int W1 = WIDTH + 1;
  localparam int AW = W1 + 1;
  localparam int CW = $clog2(W1 + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_r;
  logic [AW-1:0]      acc_r;
  logic [W1-1:0]      q_r;
  logic [W1-1:0]      m_r;
  logic               qm1_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;

  logic [AW-1:0]      sum_s;
  logic [AW-1:0]      acc_nx_s;
  logic [W1-1:0]      q_nx_s;
  logic               abort_s;

`ifdef BOOTH_SEQ_MULT_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // One extra top bit lets the signed core cover the full unsigned operand range.
  function automatic logic [W1-1:0] extend_op(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // Booth add/subtract followed by arithmetic right shift of {acc, Q}.
  always_comb begin
    sum_s = acc_r;
    case ({q_r[0], qm1_r})
      2'b01:   sum_s = acc_r + {m_r[W1-1], m_r};
      2'b10:   sum_s = acc_r - {m_r[W1-1], m_r};
      default: sum_s = acc_r;
    endcase
    acc_nx_s = {sum_s[AW-1], sum_s[AW-1:1]};
    q_nx_s   = {sum_s[0], q_r[W1-1:1]};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      q_r       <= '0;
      m_r       <= '0;
      qm1_r     <= 1'b0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            m_r     <= extend_op(multiplicand, signed_mode);
            q_r     <= extend_op(multiplier, signed_mode);
            acc_r   <= '0;
            qm1_r   <= 1'b0;
            cnt_r   <= CW'(W1);
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (abort_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            acc_r <= acc_nx_s;
            q_r   <= q_nx_s;
            qm1_r <= q_r[0];
            cnt_r <= cnt_r - CW'(1);
            // Last step: the shifted {acc, Q} already holds the full product.
            if (cnt_r == CW'(1)) begin
              product_r <= {acc_nx_s[WIDTH-2:0], q_nx_s};
              done_r    <= 1'b1;
              busy_r    <= 1'b0;
              state_r   <= IDLE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= CALC;
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=8) using a scoreboard queue of expected products.
// Abort scenarios are exercised when BOOTH_SEQ_MULT_ABORT_EN is defined.
module tb_booth_seq_mult;
  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
`ifdef BOOTH_SEQ_MULT_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] sb[$];

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef BOOTH_SEQ_MULT_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int ea;
    int eb;
    if (sgn) begin
      ea = $signed(a);
      eb = $signed(b);
    end else begin
      ea = a;
      eb = b;
    end
    return 16'(ea * eb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation, pushes its expected product and collects the DUT result.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       output int lat, output int bcnt, output logic [15:0] prod,
                       output logic [15:0] expv, output bit tmo);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sgn;
    start        = 1'b1;
    sb.push_back(model(a, b, sgn));
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    tmo = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    tmo  = !done;
    prod = product;
    expv = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplicand = 8'd0;
    multiplier = 8'd0;
`ifdef BOOTH_SEQ_MULT_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed_basic();
    int lat, bcnt;
    logic [15:0] prod, expv;
    bit tmo;
    do_op(8'd3, 8'hFC, 1'b1, lat, bcnt, prod, expv, tmo);
    checks++;
    if (tmo || lat !== LAT) begin
      errors++;
      $display("FAIL latency_3x-4: got %0d cycles (timeout=%0d), want %0d", lat, tmo, LAT);
    end
    checks++;
    if (bcnt !== LAT) begin
      errors++;
      $display("FAIL busy_len_3x-4: got %0d, want %0d", bcnt, LAT);
    end
    checks++;
    if (prod !== expv || prod !== 16'hFFF4) begin
      errors++;
      $display("FAIL prod_3x-4: got %h, want %h", prod, expv);
    end
    tick();
    checks++;
    if (done !== 1'b0 || product !== 16'hFFF4) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b product=%h, want 0 fff4", done, product);
    end
  endtask

  task automatic test_unsigned();
    logic [7:0] av[3] = '{8'd15, 8'd255, 8'd0};
    logic [7:0] bv[3] = '{8'd15, 8'd255, 8'd0};
    int lat, bcnt;
    logic [15:0] prod, expv;
    bit tmo;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], 1'b0, lat, bcnt, prod, expv, tmo);
      checks++;
      if (tmo || prod !== expv) begin
        errors++;
        $display("FAIL unsigned_%0d: got %h (timeout=%0d), want %h", i, prod, tmo, expv);
      end
      tick();
    end
  endtask

  task automatic test_signed_extremes();
    logic [7:0] av[2] = '{8'h80, 8'h80};
    logic [7:0] bv[2] = '{8'h80, 8'h7F};
    logic [15:0] kv[2] = '{16'h4000, 16'hC080};
    int lat, bcnt;
    logic [15:0] prod, expv;
    bit tmo;
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], bv[i], 1'b1, lat, bcnt, prod, expv, tmo);
      checks++;
      if (tmo || prod !== expv || prod !== kv[i]) begin
        errors++;
        $display("FAIL signed_ext_%0d: got %h (timeout=%0d), want %h", i, prod, tmo, kv[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea, eb;
    logic es;
    logic prev_busy;
    int op_cyc, ndone, last_t;
    logic [15:0] expv;
    prev_busy = busy;
    op_cyc = 0;
    ndone = 0;
    last_t = -1;
    multiplicand = 8'd2;
    multiplier = 8'd6;
    signed_mode = 1'b0;
    start = 1'b1;
    for (int t = 0; t < 55; t++) begin
      if (t == 35) start = 1'b0;
      ea = multiplicand;
      eb = multiplier;
      es = signed_mode;
      tick();
      if (busy && !prev_busy) begin
        sb.push_back(model(ea, eb, es));
        op_cyc = 0;
      end
      op_cyc++;
      // Disturb operands while the operation is in flight, restore before the next accept.
      if (op_cyc == 4) begin
        multiplicand = 8'd7;
        multiplier = 8'd9;
        signed_mode = 1'b1;
      end else if (op_cyc == 7) begin
        multiplicand = 8'd2;
        multiplier = 8'd6;
        signed_mode = 1'b0;
      end
      if (done) begin
        ndone++;
        expv = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (product !== expv || product !== 16'd12) begin
          errors++;
          $display("FAIL b2b_prod_%0d: got %h, want %h", ndone, product, expv);
        end
        if (last_t >= 0) begin
          checks++;
          if (t - last_t !== LAT + 1) begin
            errors++;
            $display("FAIL b2b_period_%0d: got %0d, want %0d", ndone, t - last_t, LAT + 1);
          end
        end
        last_t = t;
      end
      prev_busy = busy;
    end
    checks++;
    if (ndone !== 4 || sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results (%0d pending), want 4 (0)", ndone, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic [15:0] prod, expv;
    bit tmo;
    multiplicand = 8'd5;
    multiplier = 8'd7;
    signed_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    do_op(8'd1, 8'd1, 1'b0, lat, bcnt, prod, expv, tmo);
    checks++;
    if (tmo || prod !== expv || prod !== 16'd1) begin
      errors++;
      $display("FAIL after_reset_1x1: got %h (timeout=%0d), want 0001", prod, tmo);
    end
    tick();
  endtask

`ifdef BOOTH_SEQ_MULT_ABORT_EN
  task automatic test_abort();
    logic [15:0] prior;
    int nd, lat, bcnt;
    logic [15:0] prod, expv;
    bit tmo;
    prior = product;
    // Abort mid-operation.
    multiplicand = 8'd3;
    multiplier = 8'd5;
    signed_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== prior) begin
      errors++;
      $display("FAIL abort_mid: busy=%b done=%b product=%h, want 0 0 %h", busy, done, product, prior);
    end
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL abort_mid_nodone: got %0d done pulses, want 0", nd);
    end
    // Abort coincident with the final step.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== prior) begin
      errors++;
      $display("FAIL abort_final: busy=%b done=%b product=%h, want 0 0 %h", busy, done, product, prior);
    end
    tick();
    do_op(8'd3, 8'd5, 1'b0, lat, bcnt, prod, expv, tmo);
    checks++;
    if (tmo || prod !== expv || prod !== 16'd15) begin
      errors++;
      $display("FAIL abort_rerun: got %h (timeout=%0d), want 000f", prod, tmo);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_signed_basic();
    test_unsigned();
    test_signed_extremes();
    test_back_to_back();
    test_reset_mid();
`ifdef BOOTH_SEQ_MULT_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
